// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures UART receiver bytes into a DEPTH-entry first-word-fall-through FIFO.
// Latency: a byte reaches rd_data on the edge after rx_ready is seen; a pop shows the next head after its edge.
// Backpressure: none toward the receiver. Every byte is acknowledged, and bytes arriving while full are dropped and set overrun.
// Option: UART_RX_FIFO_DROP_CNT_EN adds an 8-bit saturating drop counter output drop_cnt.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    output logic          rx_ready_clr,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          overrun_clr,
    input  logic          flush
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {S_WAIT = 1'b0, S_ACK = 1'b1} state_t;

    state_t        state_q;
    logic          clr_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, full_q, overrun_q, overrun_d;
    logic          take, pop_ok, push_ok, drop;

    // A byte is taken only on the WAIT->ACK transition, so a held rx_ready pushes once.
    always_comb begin
        take    = (state_q == S_WAIT) && rx_ready;
        pop_ok  = rd_en && !empty_q && !flush;
        push_ok = take && !flush && (!full_q || pop_ok);
        drop    = take && !flush && full_q && !pop_ok;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            clr_q   <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            case (state_q)
                S_WAIT: if (rx_ready) begin
                    state_q <= S_ACK;
                    clr_q   <= 1'b1;
                end
                S_ACK:   if (!rx_ready) state_q <= S_WAIT;
                default: state_q <= S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == FULL_CNT);
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= rx_data;
    end

    assign rd_data      = empty_q ? 8'h00 : mem_q[rd_ptr_q];
    assign empty        = empty_q;
    assign full         = full_q;
    assign count        = count_q;
    assign overrun      = overrun_q;
    assign rx_ready_clr = clr_q;

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // A drop colliding with a clear restarts the count at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 8'h00;
        end else if (drop) begin
            if (overrun_clr)               drop_cnt_q <= 8'h01;
            else if (drop_cnt_q != 8'hFF)  drop_cnt_q <= drop_cnt_q + 8'h01;
        end else if (overrun_clr) begin
            drop_cnt_q <= 8'h00;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: per-cycle vector table plus scoreboard-driven fill, wrap, overrun, flush and reset sequences.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_ready_clr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       overrun_clr;
    logic       flush;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_ready_clr (rx_ready_clr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .flush        (flush)
`ifdef UART_RX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];
    int m_drop = 0;

    typedef struct {
        logic       rdy;
        logic [7:0] d;
        logic       rd;
        logic [4:0] cnt;
        logic       emp;
        logic [7:0] rdd;
        logic       clr;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit acc;
        acc = (sb.size() < DEPTH);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        chk("push_ack", 32'(rx_ready_clr), 32'd1);
        if (acc) sb.push_back(b);
        else     m_drop++;
        rx_ready = 1'b0;
        tick();
        chk("push_cnt", 32'(count), 32'(sb.size()));
    endtask

    task automatic pop_chk(input string name);
        logic [7:0] e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty on pop", name);
        end else begin
            e = sb.pop_front();
            chk(name, 32'(rd_data), 32'(e));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            chk("pop_cnt", 32'(count), 32'(sb.size()));
        end
    endtask

    initial begin
        int pulses;
        logic [7:0] e;

        reset_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; rd_en = 1'b0;
        overrun_clr = 1'b0; flush = 1'b0;
        #12;
        chk("rst_cnt",   32'(count),        32'd0);
        chk("rst_empty", 32'(empty),        32'd1);
        chk("rst_full",  32'(full),         32'd0);
        chk("rst_rdd",   32'(rd_data),      32'h00);
        chk("rst_ovr",   32'(overrun),      32'd0);
        chk("rst_clr",   32'(rx_ready_clr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 8'hA5, 1'b1};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 8'hA5, 1'b0};
        tbl[3] = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 8'hA5, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'h5A, 1'b1, 5'd1, 1'b0, 8'h5A, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h5A, 1'b0};
        tbl[7] = '{1'b1, 8'hC3, 1'b1, 5'd1, 1'b0, 8'hC3, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'hC3, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h00, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_ready = tbl[i].rdy;
            rx_data  = tbl[i].d;
            rd_en    = tbl[i].rd;
            tick();
            chk($sformatf("v%0d_cnt", i),   32'(count),        32'(tbl[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty),        32'(tbl[i].emp));
            chk($sformatf("v%0d_full", i),  32'(full),         32'd0);
            chk($sformatf("v%0d_rdd", i),   32'(rd_data),      32'(tbl[i].rdd));
            chk($sformatf("v%0d_clr", i),   32'(rx_ready_clr), 32'(tbl[i].clr));
        end
        rx_ready = 1'b0; rd_en = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) pop_chk("wrap_pop_a");
        for (int i = 16; i < 20; i++) push_byte(8'(i));
        chk("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) pop_chk("wrap_pop_b");
        chk("wrap_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        push_byte(8'hEE);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_cnt",  32'(count),   32'd16);
        chk("ovr_head", 32'(rd_data), 32'(sb[0]));
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("ovr_drop", 32'(drop_cnt), 32'(m_drop));
`endif
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("ovr_drop_clr", 32'(drop_cnt), 32'd0);
`endif

        rx_ready = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
        e = sb.pop_front();
        chk("cc_head", 32'(rd_data), 32'(e));
        sb.push_back(8'h77);
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        chk("cc_cnt", 32'(count),        32'd16);
        chk("cc_ovr", 32'(overrun),      32'd0);
        chk("cc_clr", 32'(rx_ready_clr), 32'd1);
        tick();
        for (int i = 0; i < 15; i++) pop_chk("cc_pop");
        chk("cc_last", 32'(rd_data), 32'h77);
        pop_chk("cc_pop_last");
        chk("cc_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
        push_byte(8'hEE);
        for (int i = 0; i < 11; i++) pop_chk("fl_pop");
        chk("fl_pre_cnt", 32'(count),   32'd5);
        chk("fl_pre_ovr", 32'(overrun), 32'd1);
        rx_ready = 1'b1; rx_data = 8'h99; rd_en = 1'b1; flush = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0; flush = 1'b0;
        sb.delete();
        chk("fl_cnt",   32'(count),        32'd0);
        chk("fl_empty", 32'(empty),        32'd1);
        chk("fl_ovr",   32'(overrun),      32'd1);
        chk("fl_rdd",   32'(rd_data),      32'h00);
        chk("fl_clr",   32'(rx_ready_clr), 32'd1);
        tick();
        push_byte(8'h55);
        chk("fl_after", 32'(rd_data), 32'h55);

        rx_ready = 1'b1; rx_data = 8'h3C;
        tick();
        chk("mid_clr", 32'(rx_ready_clr), 32'd1);
        chk("mid_cnt", 32'(count),        32'd2);
        #3;
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_empty", 32'(empty),        32'd1);
        chk("arst_cnt",   32'(count),        32'd0);
        chk("arst_rdd",   32'(rd_data),      32'h00);
        chk("arst_ovr",   32'(overrun),      32'd0);
        chk("arst_clr",   32'(rx_ready_clr), 32'd0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("arst_drop",  32'(drop_cnt),     32'd0);
`endif
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rx_ready_clr) pulses++;
        end
        chk("rel_pulses", 32'(pulses),  32'd1);
        chk("rel_cnt",    32'(count),   32'd1);
        chk("rel_rdd",    32'(rd_data), 32'h3C);
        rx_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
